// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered,
// mutually aligned sync, blanking, coordinate and start-pulse outputs.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned X_WIDTH    = 10,
  parameter int unsigned Y_WIDTH    = 10
) (
  input  logic               clk,
  input  logic               _reset,
  input  logic               pixEn,
  input  logic               restart,
  output logic               hSync,
  output logic               vSync,
  output logic               isVisible,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               lineStart,
  output logic               frameStart,
  output logic               vBlank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam longint unsigned X_RANGE = 64'd1 << X_WIDTH;
  localparam longint unsigned Y_RANGE = 64'd1 << Y_WIDTH;

  if (64'(H_TOTAL) > X_RANGE) begin : g_h_range_check
    $error("vga_timing_gen: H_TOTAL does not fit in X_WIDTH");
  end
  if (64'(V_TOTAL) > Y_RANGE) begin : g_v_range_check
    $error("vga_timing_gen: V_TOTAL does not fit in Y_WIDTH");
  end

  localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_TOTAL - 1);

  // Region bounds carry one extra bit so a boundary equal to 2^WIDTH stays exact.
  localparam logic [X_WIDTH:0] H_VIS_END  = (X_WIDTH+1)'(H_ACTIVE);
  localparam logic [X_WIDTH:0] H_SYNC_BEG = (X_WIDTH+1)'(H_ACTIVE + H_FRONT);
  localparam logic [X_WIDTH:0] H_SYNC_END = (X_WIDTH+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH:0] V_VIS_END  = (Y_WIDTH+1)'(V_ACTIVE);
  localparam logic [Y_WIDTH:0] V_SYNC_BEG = (Y_WIDTH+1)'(V_ACTIVE + V_FRONT);
  localparam logic [Y_WIDTH:0] V_SYNC_END = (Y_WIDTH+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [X_WIDTH-1:0] h_count;
  logic [Y_WIDTH-1:0] v_count;
  logic [X_WIDTH-1:0] h_next;
  logic [Y_WIDTH-1:0] v_next;
  logic [X_WIDTH:0]   h_ext;
  logic [Y_WIDTH:0]   v_ext;
  logic               h_visible;
  logic               v_visible;
  logic               h_sync_act;
  logic               v_sync_act;
  logic               at_line_start;
  logic               at_frame_start;

  always_comb begin
    h_ext          = {1'b0, h_count};
    v_ext          = {1'b0, v_count};
    h_visible      = h_ext < H_VIS_END;
    v_visible      = v_ext < V_VIS_END;
    h_sync_act     = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    v_sync_act     = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    at_line_start  = h_count == '0;
    at_frame_start = at_line_start && (v_count == '0);

    h_next = h_count + X_WIDTH'(1);
    v_next = v_count;
    if (h_count == H_LAST) begin
      h_next = '0;
      v_next = (v_count == V_LAST) ? '0 : v_count + Y_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      h_count    <= '0;
      v_count    <= '0;
      x          <= '0;
      y          <= '0;
      isVisible  <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      vBlank     <= 1'b0;
      hSync      <= ~H_SYNC_POL;
      vSync      <= ~V_SYNC_POL;
    end else if (restart) begin
      h_count    <= '0;
      v_count    <= '0;
      x          <= '0;
      y          <= '0;
      isVisible  <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      vBlank     <= 1'b0;
      hSync      <= ~H_SYNC_POL;
      vSync      <= ~V_SYNC_POL;
    end else begin
      // Start pulses drop on every clk edge, so they last one clk even when pixEn is sparse.
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      if (pixEn) begin
        h_count    <= h_next;
        v_count    <= v_next;
        x          <= h_count;
        y          <= v_count;
        isVisible  <= h_visible && v_visible;
        vBlank     <= !v_visible;
        hSync      <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
        vSync      <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
        lineStart  <= at_line_start;
        frameStart <= at_frame_start;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 8x6 raster, with an
// active-low and an active-high sync instance driven side by side.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       vb;
  } out_t;

  localparam out_t RESET_O = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, x: 10'd0, y: 10'd0,
                               ls: 1'b0, fs: 1'b0, vb: 1'b0};

  logic clk = 1'b0;
  logic _reset;
  logic pixEn;
  logic restart;

  logic       hs_a, vs_a, vis_a, ls_a, fs_a, vb_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vis_b, ls_b, fs_b, vb_b;
  logic [9:0] x_b, y_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), ._reset(_reset), .pixEn(pixEn), .restart(restart),
    .hSync(hs_a), .vSync(vs_a), .isVisible(vis_a), .x(x_a), .y(y_a),
    .lineStart(ls_a), .frameStart(fs_a), .vBlank(vb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), ._reset(_reset), .pixEn(pixEn), .restart(restart),
    .hSync(hs_b), .vSync(vs_b), .isVisible(vis_b), .x(x_b), .y(y_b),
    .lineStart(ls_b), .frameStart(fs_b), .vBlank(vb_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*$bits(out_t)-1:0] sb[$];
  int   slot;
  out_t held;

  function automatic out_t decode(input int s);
    int   hx, vy;
    out_t o;
    hx    = s % HT;
    vy    = s / HT;
    o.hs  = (hx >= HA + HF && hx < HA + HF + HS) ? 1'b0 : 1'b1;
    o.vs  = (vy >= VA + VF && vy < VA + VF + VS) ? 1'b0 : 1'b1;
    o.vis = (hx < HA) && (vy < VA);
    o.x   = 10'(hx);
    o.y   = 10'(vy);
    o.ls  = hx == 0;
    o.fs  = s == 0;
    o.vb  = vy >= VA;
    return o;
  endfunction

  function automatic out_t flip(input out_t o);
    out_t f;
    f    = o;
    f.hs = ~o.hs;
    f.vs = ~o.vs;
    return f;
  endfunction

  function automatic logic [2*$bits(out_t)-1:0] predict(input bit pix, input bit rs);
    if (rs) begin
      held = RESET_O;
      slot = 0;
    end else if (pix) begin
      held = decode(slot);
      slot = (slot + 1) % FT;
    end else begin
      held.ls = 1'b0;
      held.fs = 1'b0;
    end
    return {held, flip(held)};
  endfunction

  function automatic logic [2*$bits(out_t)-1:0] obs();
    return {hs_a, vs_a, vis_a, x_a, y_a, ls_a, fs_a, vb_a,
            hs_b, vs_b, vis_b, x_b, y_b, ls_b, fs_b, vb_b};
  endfunction

  task automatic drive(input bit pix, input bit rs);
    @(negedge clk);
    pixEn   = pix;
    restart = rs;
    sb.push_back(predict(pix, rs));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2*$bits(out_t)-1:0] got;
    _reset  = 1'b0;
    pixEn   = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    n_cmp++;
    if (got !== {RESET_O, flip(RESET_O)}) begin
      n_bad++;
      $display("FAIL reset_hold got=%h want=%h", got, {RESET_O, flip(RESET_O)});
    end
    @(negedge clk);
    _reset = 1'b1;
    held   = RESET_O;
    slot   = 0;
    @(posedge clk);
    #1;
    got = obs();
    n_cmp++;
    if (got !== {RESET_O, flip(RESET_O)}) begin
      n_bad++;
      $display("FAIL reset_release_idle got=%h want=%h", got, {RESET_O, flip(RESET_O)});
    end
  endtask

  task automatic test_free_run();
    logic [2*$bits(out_t)-1:0] got, exp;
    int last_fs = -1;
    int vis_cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      drive(1'b1, 1'b0);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL free_run cyc=%0d got=%h want=%h", i, got, exp);
      end
      if (vis_a) vis_cnt++;
      if (fs_a) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (i - last_fs != FT) begin
            n_bad++;
            $display("FAIL free_run_frame_len got=%0d want=%0d", i - last_fs, FT);
          end
        end
        last_fs = i;
      end
    end
    n_cmp++;
    if (vis_cnt != 2 * HA * VA) begin
      n_bad++;
      $display("FAIL free_run_visible_count got=%0d want=%0d", vis_cnt, 2 * HA * VA);
    end
  endtask

  task automatic test_pix_toggle();
    logic [2*$bits(out_t)-1:0] got, exp;
    int last_fs = -1;
    for (int i = 0; i < 4 * FT; i++) begin
      drive((i % 2) == 0, 1'b0);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pix_toggle cyc=%0d got=%h want=%h", i, got, exp);
      end
      if (fs_a) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (i - last_fs != 2 * FT) begin
            n_bad++;
            $display("FAIL pix_toggle_frame_len got=%0d want=%0d", i - last_fs, 2 * FT);
          end
        end
        last_fs = i;
      end
    end
  endtask

  task automatic test_restart();
    logic [2*$bits(out_t)-1:0] got, exp;
    bit pix_seq[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit rs_seq[10]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 1'b0);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL restart_lead cyc=%0d got=%h want=%h", i, got, exp);
      end
    end
    // mid-line restart with pixEn low, then with pixEn high, each followed by a frame start
    for (int i = 0; i < 10; i++) begin
      drive(pix_seq[i], rs_seq[i]);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL restart step=%0d got=%h want=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2*$bits(out_t)-1:0] got, exp;
    for (int i = 0; i < HT && held.x != 10'(HA + HF); i++) begin
      drive(1'b1, 1'b0);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL async_lead cyc=%0d got=%h want=%h", i, got, exp);
      end
    end
    n_cmp++;
    if (hs_a !== 1'b0 || hs_b !== 1'b1) begin
      n_bad++;
      $display("FAIL async_in_hsync got=%b%b want=01", hs_a, hs_b);
    end
    #2;
    _reset = 1'b0;
    #1;
    got = obs();
    n_cmp++;
    if (got !== {RESET_O, flip(RESET_O)}) begin
      n_bad++;
      $display("FAIL async_reset_immediate got=%h want=%h", got, {RESET_O, flip(RESET_O)});
    end
    @(negedge clk);
    pixEn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    _reset = 1'b1;
    held   = RESET_O;
    slot   = 0;
    for (int i = 0; i < HT + 2; i++) begin
      drive(1'b1, 1'b0);
      got = obs();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL async_after cyc=%0d got=%h want=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pix_toggle();
    test_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The module SHALL have parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2 and V_BACK 33, the same four timing regions in lines.
REQ-006 The module SHALL have parameters H_SYNC_POL and V_SYNC_POL, default 0, each the active level of its sync pulse (0 = active-low).
REQ-007 The module SHALL have parameters X_WIDTH, default 10, and Y_WIDTH, default 10, the coordinate output widths.
REQ-008 clk  input  1  pixel-domain clock; all state changes on its rising edge.
REQ-009 _reset  input  1  asynchronous, active-low reset.
REQ-010 pixEn  input  1  pixel-slot enable; counters and output registers advance only on clk edges with pixEn=1.
REQ-011 restart  input  1  synchronous restart of the frame; takes priority over pixEn.
REQ-012 hSync, vSync  output  1 each  sync pulses at the polarity set by H_SYNC_POL and V_SYNC_POL.
REQ-013 isVisible  output  1  high while the current pixel slot lies in the active area.
REQ-014 x  output  X_WIDTH  horizontal pixel coordinate; y  output  Y_WIDTH  line coordinate.
REQ-015 lineStart, frameStart  output  1 each  single-clk pulses marking coordinate (0,*) and (0,0).
REQ-016 vBlank  output  1  high while the line coordinate is V_ACTIVE or greater.

Function
REQ-017 Totals: H_TOTAL = sum of the four H regions, V_TOTAL = sum of the four V regions; the block SHALL require H_TOTAL <= 2^X_WIDTH and V_TOTAL <= 2^Y_WIDTH.
REQ-018 On a pixEn edge, hCount SHALL go to 0 if it equals H_TOTAL-1, otherwise hCount+1.
REQ-019 vCount SHALL advance only on a pixEn edge where hCount = H_TOTAL-1, going to 0 if it equals V_TOTAL-1, otherwise vCount+1.
REQ-020 On each pixEn edge, the output registers SHALL capture the decode of the pre-edge counters, giving 1 pixel-slot latency; all outputs SHALL stay mutually aligned.
REQ-021 Captured values: x = hCount and y = vCount.
REQ-022 Captured value: isVisible = (hCount < H_ACTIVE) and (vCount < V_ACTIVE).
REQ-023 Captured value: vBlank = (vCount >= V_ACTIVE).
REQ-024 hSync active level for H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC, inactive otherwise.
REQ-025 vSync active level for V_ACTIVE+V_FRONT <= vCount < V_ACTIVE+V_FRONT+V_SYNC, for all hCount; inactive otherwise.
REQ-026 lineStart SHALL go high on a pixEn edge with hCount = 0 and clear on the next clk edge regardless of pixEn, so its width is exactly one clk.
REQ-027 frameStart SHALL behave the same with the condition hCount = 0 and vCount = 0.
REQ-028 On a pixEn=0 edge, counters and all outputs except the pulse clears SHALL hold.
REQ-029 restart=1 at a clk edge SHALL load counters to 0 and all outputs to their reset values, whatever pixEn is; the next pixEn edge then emits frameStart.

Reset
REQ-030 _reset low SHALL immediately clear hCount, vCount, x, y, isVisible, lineStart and frameStart to 0.
REQ-031 During reset, hSync SHALL be ~H_SYNC_POL and vSync ~V_SYNC_POL (inactive), and vBlank SHALL be 0.
REQ-032 A reset asserted mid-line or mid-frame SHALL abandon the frame with no partial pulse beyond the reset edge.
REQ-033 After release, the first pixEn edge SHALL output x=0, y=0, isVisible=1, lineStart=1 and frameStart=1.

Verification
REQ-034 Defaults, pixEn always 1, release reset -> frameStart every 420000 clks; hSync low for clks 656..751 of each line relative to lineStart (x=0); vSync low on lines 490..491; isVisible count 307200 per frame.
REQ-035 Small params H 4/1/2/1, V 3/1/1/1, pixEn=1 -> x sequence 0..7 repeating, hSync active at x=5,6, isVisible at x=0..3 on y=0..2, frame length 48 clks.
REQ-036 pixEn toggling 1,0 -> frame length doubles; lineStart and frameStart remain 1 clk wide; x and y hold on pixEn=0 cycles.
REQ-037 restart pulsed at x=300, y=200 with pixEn=0 -> next clk outputs reset values; the next pixEn edge gives x=0, y=0 and frameStart=1.
REQ-038 _reset asserted asynchronously mid-hSync -> hSync goes inactive without waiting for a clk edge; the first post-release pixEn edge matches REQ-033.
REQ-039 H_SYNC_POL=1, V_SYNC_POL=1 -> the syncs are idle-low and pulse high at the same positions as REQ-034.
